// File: rtl/core_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : core_pkg
// Purpose  : Shared types and constants for the memory port sequencer:
//            sequencer state encoding, bus owner encoding, reset vector.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package core_pkg;

  localparam int               CORE_ADDR_W    = 16;
  localparam logic [15:0]      CORE_RESET_VEC = 16'hFFFC;

  typedef enum logic [2:0] {
    BOOT_START = 3'd0,
    BOOT_LO    = 3'd1,
    BOOT_HI    = 3'd2,
    ARB        = 3'd3,
    BUSY       = 3'd4
  } seq_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_pc_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_pc_counter
// Purpose  : Holds the next prefetch address. A load (boot vector or
//            redirect) takes priority over an increment; the increment wraps
//            naturally at the top of the address space.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module fetch_pc_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: load beats increment so a redirect always wins over a push.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_val;
    end else if (inc_en) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : fetch_pc_counter
`default_nettype wire

// File: rtl/mem_port_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_port_sequencer
// Purpose  : Shares the single 8-bit memory port between the instruction
//            prefetcher and execute-stage data accesses, performs the
//            reset-vector fetch and handles branch redirects.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mem_port_sequencer
  import core_pkg::*;
#(
  parameter int                RESET_VEC_W = CORE_ADDR_W,
  parameter int                ADDR_W      = RESET_VEC_W,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(CORE_RESET_VEC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic              dreq_we,
  input  logic [7:0]        dreq_wdata,
  output logic              dreq_ready,
  output logic [7:0]        dreq_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              q_full,
  output logic              q_push,
  output logic [7:0]        q_data,
  output logic              q_reset,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              boot_done
);

  seq_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              discard_q, discard_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              q_reset_q, q_reset_d;
  logic              boot_done_q, boot_done_d;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              busy_ack;

  assign busy_ack = (state_q == BUSY) && mem_ack;

  // A fetched byte is pushed only if no redirect has made it stale.
  assign q_push     = busy_ack && (owner_q == OWN_FETCH) && !discard_q && !redirect_valid;
  assign q_data     = mem_rdata;
  assign dreq_ready = busy_ack && (owner_q == OWN_DATA);
  assign dreq_rdata = mem_rdata;

  assign mem_req    = (state_q == BOOT_LO) || (state_q == BOOT_HI) || (state_q == BUSY);
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign q_reset    = q_reset_q;
  assign boot_done  = boot_done_q;

  fetch_pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_fetch_pc (
    .clk      (clk),
    .reset    (reset),
    .load_en  (pc_load),
    .load_val (pc_load_val),
    .inc_en   (q_push),
    .pc       (fetch_pc)
  );

  // Boot, arbitration and transaction tracking: next-state computation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    q_reset_d   = 1'b0;
    boot_done_d = boot_done_q;
    pc_load     = 1'b0;
    pc_load_val = redirect_addr;

    case (state_q)
      BOOT_START: begin
        // Address is set up here so it is already stable when mem_req rises.
        mem_addr_d = RESET_VEC;
        mem_we_d   = 1'b0;
        state_d    = BOOT_LO;
      end
      BOOT_LO: begin
        if (mem_ack) begin
          lo_d       = mem_rdata;
          mem_addr_d = RESET_VEC + ADDR_W'(1);
          state_d    = BOOT_HI;
        end
      end
      BOOT_HI: begin
        if (mem_ack) begin
          pc_load     = 1'b1;
          pc_load_val = ADDR_W'({mem_rdata, lo_q});
          boot_done_d = 1'b1;
          state_d     = ARB;
        end
      end
      ARB: begin
        if (redirect_valid) begin
          pc_load   = 1'b1;
          q_reset_d = 1'b1;
        end else if (dreq_valid) begin
          mem_addr_d  = dreq_addr;
          mem_we_d    = dreq_we;
          mem_wdata_d = dreq_wdata;
          owner_d     = OWN_DATA;
          state_d     = BUSY;
        end else if (!q_full) begin
          mem_addr_d = fetch_pc;
          mem_we_d   = 1'b0;
          owner_d    = OWN_FETCH;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (redirect_valid) begin
          pc_load   = 1'b1;
          q_reset_d = 1'b1;
          // The bus cycle runs to completion; its byte is just thrown away.
          if ((owner_q == OWN_FETCH) && !mem_ack) begin
            discard_d = 1'b1;
          end
        end
        if (mem_ack) begin
          state_d = ARB;
          if (owner_q == OWN_FETCH) begin
            discard_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = BOOT_START;
      end
    endcase
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT_START;
      owner_q     <= OWN_FETCH;
      discard_q   <= 1'b0;
      lo_q        <= 8'h00;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      q_reset_q   <= 1'b0;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      lo_q        <= lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      q_reset_q   <= q_reset_d;
      boot_done_q <= boot_done_d;
    end
  end

endmodule : mem_port_sequencer
`default_nettype wire
